// File: rtl/f_pc_fd_reg_if.sv
// Signal bundle between the fetch/decode pipeline register and its neighbours
// (CP0, hazard unit, next-PC logic and instruction memory).
interface f_pc_fd_reg_if;
  logic        Req;
  logic        stall;
  logic        eret;
  logic        D_jump;
  logic [31:0] NPC;
  logic [31:0] i_inst_rdata;
  logic [31:0] i_inst_addr;
  logic [31:0] F_PC;
  logic [31:0] D_PC;
  logic [31:0] D_Instr;
  logic [4:0]  D_ExcCode;
  logic        D_BD;
  logic        D_valid;

  modport master (
    output Req, stall, eret, D_jump, NPC, i_inst_rdata,
    input  i_inst_addr, F_PC, D_PC, D_Instr, D_ExcCode, D_BD, D_valid
  );

  modport slave (
    input  Req, stall, eret, D_jump, NPC, i_inst_rdata,
    output i_inst_addr, F_PC, D_PC, D_Instr, D_ExcCode, D_BD, D_valid
  );
endinterface

// File: rtl/f_pc_fd_reg.sv
// Fetch PC register plus F/D pipeline register: checks the fetch address,
// tags delay slots and bubbles/flushes D on exception request or eret.
module f_pc_fd_reg #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI    = 32'h0000_6ffc,
  parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
  input logic          clk,
  input logic          reset,
  f_pc_fd_reg_if.slave bus
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned EXCW = 5;

  logic [XLEN-1:0] f_pc;
  logic [XLEN-1:0] d_pc;
  logic [XLEN-1:0] d_instr;
  logic [EXCW-1:0] d_exc_code;
  logic            d_bd;
  logic            d_valid;

  logic            f_exc_c;
  logic [XLEN-1:0] f_instr_c;
  logic [EXCW-1:0] f_exc_code_c;

  // Fetch address check; a faulting fetch carries a NOP word into D
  always_comb begin
    f_exc_c      = (f_pc[1:0] != 2'b00) || (f_pc < TEXT_LO) || (f_pc > TEXT_HI);
    f_instr_c    = f_exc_c ? '0 : bus.i_inst_rdata;
    f_exc_code_c = f_exc_c ? EXC_ADEL : '0;
  end

  // PC register: Req overrides stall; NPC already holds the handler address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_pc <= RESET_PC;
    end else if (bus.Req || !bus.stall) begin
      f_pc <= bus.NPC;
    end
  end

  // F/D register: Req bubble > stall hold > eret flush > normal advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_pc       <= RESET_PC;
      d_instr    <= '0;
      d_exc_code <= '0;
      d_bd       <= 1'b0;
      d_valid    <= 1'b0;
    end else if (bus.Req) begin
      d_pc       <= HANDLER_PC;
      d_instr    <= '0;
      d_exc_code <= '0;
      d_bd       <= 1'b0;
      d_valid    <= 1'b0;
    end else if (bus.stall) begin
      d_pc       <= d_pc;
    end else if (bus.eret) begin
      d_pc       <= f_pc;
      d_instr    <= '0;
      d_exc_code <= '0;
      d_bd       <= 1'b0;
      d_valid    <= 1'b0;
    end else begin
      d_pc       <= f_pc;
      d_instr    <= f_instr_c;
      d_exc_code <= f_exc_code_c;
      d_bd       <= bus.D_jump;
      d_valid    <= 1'b1;
    end
  end

  assign bus.i_inst_addr = f_pc;
  assign bus.F_PC        = f_pc;
  assign bus.D_PC        = d_pc;
  assign bus.D_Instr     = d_instr;
  assign bus.D_ExcCode   = d_exc_code;
  assign bus.D_BD        = d_bd;
  assign bus.D_valid     = d_valid;

endmodule

// File: tb/tb_f_pc_fd_reg.sv
// Directed bench for f_pc_fd_reg: sequential fetch, stall, AdEL, delay slot,
// Req bubble, eret flush and asynchronous reset, with hand-computed expectations.
module tb_f_pc_fd_reg;

  localparam logic [31:0] I_ADDIU = 32'h2401_0005;
  localparam logic [31:0] I_LW    = 32'h8c22_0000;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  f_pc_fd_reg_if bus ();

  f_pc_fd_reg dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string step, input logic [31:0] f_pc, input logic [31:0] d_pc,
                           input logic [31:0] d_instr, input logic [4:0] exc,
                           input logic bd, input logic valid);
    check_eq({step, ".F_PC"},      bus.F_PC, f_pc);
    check_eq({step, ".i_addr"},    bus.i_inst_addr, f_pc);
    check_eq({step, ".D_PC"},      bus.D_PC, d_pc);
    check_eq({step, ".D_Instr"},   bus.D_Instr, d_instr);
    check_eq({step, ".D_ExcCode"}, 32'(bus.D_ExcCode), 32'(exc));
    check_eq({step, ".D_BD"},      32'(bus.D_BD), 32'(bd));
    check_eq({step, ".D_valid"},   32'(bus.D_valid), 32'(valid));
  endtask

  // Advance one edge and sample 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset            = 1'b1;
    bus.Req          = 1'b0;
    bus.stall        = 1'b0;
    bus.eret         = 1'b0;
    bus.D_jump       = 1'b0;
    bus.NPC          = 32'h3004;
    bus.i_inst_rdata = I_ADDIU;
    #12;
    check_all("reset", 32'h3000, 32'h3000, 32'h0, 5'd0, 1'b0, 1'b0);
    #1 reset = 1'b0;

    tick(); check_all("seq1", 32'h3004, 32'h3000, I_ADDIU, 5'd0, 1'b0, 1'b1);
    bus.NPC = 32'h3008;
    tick(); check_all("seq2", 32'h3008, 32'h3004, I_ADDIU, 5'd0, 1'b0, 1'b1);

    bus.stall = 1'b1; bus.NPC = 32'h300c;
    tick(); check_all("stall1", 32'h3008, 32'h3004, I_ADDIU, 5'd0, 1'b0, 1'b1);
    tick(); check_all("stall2", 32'h3008, 32'h3004, I_ADDIU, 5'd0, 1'b0, 1'b1);
    bus.stall = 1'b0;
    tick(); check_all("resume", 32'h300c, 32'h3008, I_ADDIU, 5'd0, 1'b0, 1'b1);

    bus.NPC = 32'h3002;
    tick(); check_all("mis_f", 32'h3002, 32'h300c, I_ADDIU, 5'd0, 1'b0, 1'b1);
    bus.NPC = 32'h3010;
    tick(); check_all("mis_d", 32'h3010, 32'h3002, 32'h0, 5'd4, 1'b0, 1'b1);

    bus.D_jump = 1'b1; bus.NPC = 32'h7000;
    tick(); check_all("bd1", 32'h7000, 32'h3010, I_ADDIU, 5'd0, 1'b1, 1'b1);
    bus.D_jump = 1'b0; bus.NPC = 32'h3014;
    tick(); check_all("hi_d", 32'h3014, 32'h7000, 32'h0, 5'd4, 1'b0, 1'b1);
    bus.NPC = 32'h3018;
    tick(); check_all("bd0", 32'h3018, 32'h3014, I_ADDIU, 5'd0, 1'b0, 1'b1);

    bus.Req = 1'b1; bus.stall = 1'b1; bus.D_jump = 1'b1; bus.NPC = 32'h4180;
    tick(); check_all("req", 32'h4180, 32'h4180, 32'h0, 5'd0, 1'b0, 1'b0);
    bus.Req = 1'b0; bus.stall = 1'b0; bus.D_jump = 1'b0; bus.NPC = 32'h3020;
    bus.i_inst_rdata = I_LW;
    tick(); check_all("handler", 32'h3020, 32'h4180, I_LW, 5'd0, 1'b0, 1'b1);

    bus.eret = 1'b1; bus.stall = 1'b1; bus.NPC = 32'h3104;
    tick(); check_all("eret_stall", 32'h3020, 32'h4180, I_LW, 5'd0, 1'b0, 1'b1);
    bus.stall = 1'b0;
    tick(); check_all("eret", 32'h3104, 32'h3020, 32'h0, 5'd0, 1'b0, 1'b0);
    bus.eret = 1'b0; bus.NPC = 32'h6ffc;
    tick(); check_all("post_eret", 32'h6ffc, 32'h3104, I_LW, 5'd0, 1'b0, 1'b1);

    bus.NPC = 32'h2ffc;
    tick(); check_all("top_ok", 32'h2ffc, 32'h6ffc, I_LW, 5'd0, 1'b0, 1'b1);
    bus.NPC = 32'h3004;
    tick(); check_all("low_bad", 32'h3004, 32'h2ffc, 32'h0, 5'd4, 1'b0, 1'b1);

    // Asynchronous reset mid-stall, away from any clock edge
    bus.stall = 1'b1;
    #2 reset = 1'b1;
    #1 check_all("async_rst", 32'h3000, 32'h3000, 32'h0, 5'd0, 1'b0, 1'b0);
    #3 reset = 1'b0; bus.stall = 1'b0; bus.NPC = 32'h3004; bus.i_inst_rdata = I_ADDIU;
    tick(); check_all("rst_fetch", 32'h3004, 32'h3000, I_ADDIU, 5'd0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
